uart_tx_scheduler: RTL and testbench

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_tx_scheduler_pkg.sv | 15 +
 rtl/uart_tx_scheduler_rr_arb2.sv | 38 +++
 rtl/uart_tx_scheduler.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the two-requester UART transmit scheduler.
package uart_tx_scheduler_pkg;

    localparam int DATA_W_DEF    = 8;
    localparam int STOP_BITS_DEF = 1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_START = 3'd1,
        START      = 3'd2,
        DATA       = 3'd3,
        STOP       = 3'd4
    } state_e;

endpackage

// File: rtl/uart_tx_scheduler_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, registered last winner.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic [1:0] gnt_o,
    output logic       last_o
);

    logic last_q, last_d;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        last_d = last_q;
        if (update_i && (gnt_o != 2'b00)) begin
            last_d = gnt_o[1];
        end
    end

    // Reset value 1 marks requester 1 as last winner, so requester 0 goes first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_o = last_q;

endmodule

// File: rtl/uart_tx_scheduler.sv
// UART frame transmitter shared by two requesters via round-robin arbitration.
//   IDLE       | line high, waiting for a request
//   WAIT_START | granted, waiting for first baud_tick
//   START      | start bit (0) on the line
//   DATA       | data bits, LSB first
//   STOP       | stop bit(s) (1) on the line
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int STOP_BITS = STOP_BITS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud_tick,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic              owner
);

    localparam int               CNT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [1:0]       STOP_LAST = 2'(STOP_BITS - 1);

    state_e            state_q, state_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              owner_q, owner_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [1:0]        stop_cnt_q, stop_cnt_d;

    logic [1:0]        arb_gnt;
    logic              arb_update;
    logic              arb_last_unused;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    ({req1, req0}),
        .update_i (arb_update),
        .gnt_o    (arb_gnt),
        .last_o   (arb_last_unused)
    );

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        owner_d    = owner_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        arb_update = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    arb_update = 1'b1;
                    gnt0_d     = arb_gnt[0];
                    gnt1_d     = arb_gnt[1];
                    owner_d    = arb_gnt[1];
                    shreg_d    = arb_gnt[1] ? data1 : data0;
                    busy_d     = 1'b1;
                    state_d    = WAIT_START;
                end
            end
            WAIT_START: begin
                if (baud_tick) begin
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    tx_d      = shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        tx_d       = 1'b1;
                        stop_cnt_d = 2'd0;
                        state_d    = STOP;
                    end else begin
                        tx_d      = shreg_q[0];
                        shreg_d   = shreg_q >> 1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        stop_cnt_d = 2'd0;
                        bit_cnt_d  = '0;
                        state_d    = IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 2'd1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            owner_q    <= 1'b0;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            owner_q    <= owner_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
        end
    end

    assign gnt0  = gnt0_q;
    assign gnt1  = gnt1_q;
    assign tx    = tx_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign owner = owner_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench: a tick-indexed frame model checks every cycle; a line decoder and grant log back the table cases.
module tb_uart_tx_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] data0 = 8'h00, data1 = 8'h00;
    logic       gnt0, gnt1, tx, busy, done, owner;

    logic       b_req0 = 1'b0, b_req1 = 1'b0;
    logic [7:0] b_data0 = 8'h00, b_data1 = 8'h00;
    logic       b_gnt0, b_gnt1, b_tx, b_busy, b_done, b_owner;

    uart_tx_scheduler #(.DATA_W(8), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .baud_tick(baud_tick),
        .req0(req0), .req1(req1), .data0(data0), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .tx(tx), .busy(busy), .done(done), .owner(owner)
    );

    uart_tx_scheduler #(.DATA_W(8), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick),
        .req0(b_req0), .req1(b_req1), .data0(b_data0), .data1(b_data1),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .tx(b_tx), .busy(b_busy), .done(b_done), .owner(b_owner)
    );

    always #5 clk = ~clk;

    // Reference: a frame is the level list {0, d[0..7], 1}; the k-th tick after the grant
    // puts level k-1 on the line, and tick 10+STOP_BITS ends the frame.
    typedef struct {
        bit       active;
        int       k;
        bit       tx;
        bit       owner;
        bit       last;
        bit [7:0] dat;
        bit       busy;
        bit       done;
        bit       g0;
        bit       g1;
    } mdl_t;

    typedef struct {
        bit       do_rst;
        bit       r0;
        bit       r1;
        bit [7:0] d0;
        bit [7:0] d1;
        int       exp_n;
        bit       exp_first;
        bit [7:0] exp_b0;
        bit [7:0] exp_b1;
    } vec_t;

    mdl_t     m1, m2;
    int       n_cmp = 0, n_err = 0;
    int       cyc = 0, phase = 0;
    int       n_done = 0, t_done = -1000, gap_g1 = -1;
    bit       in_frame = 0;
    int       idx = 0;
    bit [7:0] rx_sh;
    bit [7:0] rx_q[$];
    bit       g_log[$];
    bit       b_seen_low = 0;
    int       b_stop_len = 0, last_stop_len = -1;
    vec_t     vecs[7];

    function automatic void mdl_step(inout mdl_t m, input int nstop, input bit r,
                                     input bit r0, input bit r1,
                                     input bit [7:0] d0, input bit [7:0] d1, input bit tk);
        bit w;
        m.g0 = 0; m.g1 = 0; m.done = 0;
        if (r) begin
            m.active = 0; m.tx = 1; m.owner = 0; m.last = 1; m.busy = 0; m.k = 0;
        end else if (!m.active) begin
            if (r0 || r1) begin
                w = (r0 && r1) ? !m.last : r1;
                m.owner = w; m.last = w; m.dat = w ? d1 : d0;
                m.g0 = !w; m.g1 = w; m.active = 1; m.busy = 1; m.k = 0;
            end
        end else if (tk) begin
            m.k++;
            if (m.k == 1)      m.tx = 0;
            else if (m.k <= 9) m.tx = m.dat[m.k-2];
            else               m.tx = 1;
            if (m.k == 10 + nstop) begin
                m.active = 0; m.busy = 0; m.done = 1;
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        mdl_step(m1, 1, rst, req0, req1, data0, data1, baud_tick);
        mdl_step(m2, 2, rst, b_req0, b_req1, b_data0, b_data1, baud_tick);
        #1;
        cyc++;
        chk("u1 {gnt0,gnt1,owner,busy,done,tx}", {26'd0, gnt0, gnt1, owner, busy, done, tx},
            {26'd0, m1.g0, m1.g1, m1.owner, m1.busy, m1.done, m1.tx});
        chk("u2 {gnt0,gnt1,owner,busy,done,tx}", {26'd0, b_gnt0, b_gnt1, b_owner, b_busy, b_done, b_tx},
            {26'd0, m2.g0, m2.g1, m2.owner, m2.busy, m2.done, m2.tx});
        if (gnt0) begin req0 = 0; g_log.push_back(1'b0); end
        if (gnt1) begin req1 = 0; g_log.push_back(1'b1); gap_g1 = cyc - t_done; end
        if (done) begin n_done++; t_done = cyc; end
        if (b_gnt0) b_req0 = 0;
        if (b_gnt1) b_req1 = 0;
        if (!b_tx) b_seen_low = 1;
        if (b_busy && b_tx && b_seen_low) b_stop_len++;
        if (b_done || !b_busy) begin
            if (b_done) last_stop_len = b_stop_len;
            b_stop_len = 0; b_seen_low = 0;
        end
        phase = (phase + 1) % 16;
        baud_tick = (phase == 0);
        if (!busy) in_frame = 0;
        if (!in_frame && busy && !tx) begin in_frame = 1; idx = 0; end
        if (in_frame && baud_tick) begin
            if (idx >= 1 && idx <= 8) rx_sh[idx-1] = tx;
            if (idx == 9) begin rx_q.push_back(rx_sh); in_frame = 0; end
            idx++;
        end
    endtask

    task automatic do_reset();
        rst = 1; cycle(); cycle(); rst = 0;
    endtask

    task automatic run_idle(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            cycle();
            if (!m1.active && !m2.active && !req0 && !req1 && !b_req0 && !b_req1) break;
        end
        if (i == budget) begin
            n_cmp++; n_err++;
            $display("FAIL idle timeout: still busy after %0d cycles", budget);
        end
        cycle();
    endtask

    initial begin
        vecs[0] = '{1, 1, 0, 8'hA5, 8'h00, 1, 0, 8'hA5, 8'h00};
        vecs[1] = '{1, 1, 1, 8'h11, 8'h22, 2, 0, 8'h11, 8'h22};
        vecs[2] = '{0, 1, 1, 8'h11, 8'h22, 2, 0, 8'h11, 8'h22};
        vecs[3] = '{0, 0, 1, 8'h00, 8'h7E, 1, 1, 8'h7E, 8'h00};
        vecs[4] = '{0, 1, 1, 8'h33, 8'h44, 2, 0, 8'h33, 8'h44};
        vecs[5] = '{0, 1, 0, 8'h81, 8'h00, 1, 0, 8'h81, 8'h00};
        vecs[6] = '{0, 1, 1, 8'h0F, 8'hF0, 2, 1, 8'hF0, 8'h0F};

        do_reset();
        chk("reset tx", tx, 1);
        chk("reset busy", busy, 0);

        foreach (vecs[v]) begin
            rx_q.delete(); g_log.delete();
            if (vecs[v].do_rst) do_reset();
            req0 = vecs[v].r0; req1 = vecs[v].r1;
            data0 = vecs[v].d0; data1 = vecs[v].d1;
            run_idle(800);
            chk($sformatf("vec%0d grants", v), g_log.size(), vecs[v].exp_n);
            chk($sformatf("vec%0d first owner", v), (g_log.size() > 0) ? g_log[0] : 1'bx, vecs[v].exp_first);
            chk($sformatf("vec%0d frames", v), rx_q.size(), vecs[v].exp_n);
            chk($sformatf("vec%0d byte0", v), (rx_q.size() > 0) ? rx_q[0] : 8'hxx, vecs[v].exp_b0);
            if (vecs[v].exp_n == 2)
                chk($sformatf("vec%0d byte1", v), (rx_q.size() > 1) ? rx_q[1] : 8'hxx, vecs[v].exp_b1);
        end

        // request while busy
        do_reset(); rx_q.delete(); gap_g1 = -1;
        req0 = 1; data0 = 8'h5A;
        repeat (60) cycle();
        chk("busy req1 no early gnt", gap_g1, -1);
        req1 = 1; data1 = 8'hC3;
        run_idle(800);
        chk("gnt1 one edge after done", gap_g1, 1);
        chk("busy case frames", rx_q.size(), 2);
        chk("busy case byte1", (rx_q.size() > 1) ? rx_q[1] : 8'hxx, 8'hC3);

        // reset during data bit 3
        do_reset(); rx_q.delete();
        req0 = 1; data0 = 8'h96;
        for (int i = 0; i < 400 && m1.k != 5; i++) cycle();
        chk("reached bit3", m1.k, 5);
        repeat (4) cycle();
        begin
            int nd;
            nd = n_done;
            rst = 1; cycle(); rst = 0;
            chk("abort tx", tx, 1);
            chk("abort busy", busy, 0);
            repeat (40) cycle();
            chk("abort no done", n_done, nd);
            chk("abort no frame", rx_q.size(), 0);
        end
        req0 = 1; data0 = 8'h3C;
        run_idle(800);
        chk("after abort byte", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h3C);

        // data change after grant
        do_reset(); rx_q.delete();
        req0 = 1; data0 = 8'h55;
        for (int i = 0; i < 50 && req0; i++) cycle();
        cycle();
        data0 = 8'hFF;
        run_idle(800);
        chk("stable data byte", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h55);

        // two stop bits
        do_reset(); last_stop_len = -1;
        b_req0 = 1; b_data0 = 8'h00;
        run_idle(800);
        chk("2 stop bits high cycles", last_stop_len, 32);

        // randomized traffic against the model
        for (int i = 0; i < 6000; i++) begin
            rst = ($urandom_range(0, 2999) == 0);
            if (!req0 && $urandom_range(0, 39) == 0) begin req0 = 1; data0 = 8'($urandom_range(0, 255)); end
            else if (req0 && $urandom_range(0, 299) == 0) req0 = 0;
            if (!req1 && $urandom_range(0, 39) == 0) begin req1 = 1; data1 = 8'($urandom_range(0, 255)); end
            else if (req1 && $urandom_range(0, 299) == 0) req1 = 0;
            if (!b_req0 && $urandom_range(0, 49) == 0) begin b_req0 = 1; b_data0 = 8'($urandom_range(0, 255)); end
            if (!b_req1 && $urandom_range(0, 49) == 0) begin b_req1 = 1; b_data1 = 8'($urandom_range(0, 255)); end
            cycle();
        end
        rst = 0;
        run_idle(1500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
